fc1_seq_ctrl: RTL and testbench
===============================

# fc1_seq_ctrl

Sequencer for the fully connected layer-1 PE array. On a `start` pulse it clears the PE accumulators, then streams input-memory and weight-memory read addresses 0..INPUT_NODES-1 at one per cycle. It aligns the PE `valid` strobe to the memory read latency and waits for the PE pipeline to drain. It then pulses `done` and `out_latch` so downstream logic can capture the OUTPUT_NODES results. It sits between the network-level scheduler and the FC1 memories/PE array.

## Interface
Parameters:
- INPUT_NODES, 784, number of accumulate steps per inference
- ADDR_W, 10, address width; must satisfy 2**ADDR_W >= INPUT_NODES
- MEM_LAT, 1, input/weight memory read latency in cycles (legal 1..4)
- PE_LAT, 2, cycles from the last PE `valid` until the PE result is stable

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to run one pass; honoured only in IDLE
- pause  in  1  freezes address issue (present only with FC1_CTRL_PAUSE_EN)
- rd_en  out  1  memory read enable
- addra  out  ADDR_W  memory read address shared by input and weight memories
- pe_valid  out  1  PE accumulate strobe, rd_en delayed MEM_LAT cycles
- pe_clear  out  1  one-cycle accumulator clear; top level ORs it into the PE reset
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- out_latch  out  1  capture strobe for the output register bank, coincident with done

## Operation
- FSM states and transitions:
  - IDLE: `start` → CLEAR.
  - CLEAR: lasts 1 cycle. Asserts pe_clear and zeroes the address counter. → RUN.
  - RUN: rd_en=1 and addra increments by 1 per cycle. When the cycle issuing addra=INPUT_NODES-1 completes, → DRAIN.
  - DRAIN: a counter runs MEM_LAT+PE_LAT cycles with rd_en=0, then → DONE.
  - DONE: lasts 1 cycle. Asserts done and out_latch. → IDLE.
- Delay line: pe_valid is a MEM_LAT-deep shift register of rd_en. Every issued address produces exactly one pe_valid, so there are INPUT_NODES pe_valid pulses per pass.
- Address counter:
  - Width ADDR_W, cleared in CLEAR.
  - After the last issue, addra holds INPUT_NODES-1 until the next CLEAR.
  - The counter never wraps; the RUN exit compare is on INPUT_NODES-1.
- `start` is ignored outside IDLE, including in the DONE cycle. It is not queued.
- Reset:
  - All outputs go to 0 and addra to 0; the state goes to IDLE.
  - The delay line is flushed.
  - A reset mid-pass aborts the pass with no done pulse.
- Reset values: rd_en=0, addra=0, pe_valid=0, pe_clear=0, busy=0, done=0, out_latch=0.

## Timing
Cycle n means the state after n clock edges, with start high in cycle 0.
- Pass timeline, with T = INPUT_NODES and D = MEM_LAT+PE_LAT:
  - cycle 1: CLEAR, pe_clear=1, busy=1.
  - cycles 2..T+1: RUN, addra=0..T-1.
  - pe_valid high in cycles 2+MEM_LAT .. T+1+MEM_LAT.
  - cycles T+2 .. T+1+D: DRAIN.
  - cycle T+2+D: done=1, out_latch=1.
  - cycle T+3+D: IDLE, busy=0.
- With defaults, done is in cycle 789 and back-to-back passes restart every 790 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FC1_CTRL_PAUSE_EN defined:
  - The `pause` port exists. `pause`=1 in RUN deasserts rd_en and holds addra and the state.
  - pe_valid follows rd_en through the delay line, so gaps propagate.
  - `pause` is ignored in CLEAR, DRAIN and DONE.
  - Each paused cycle extends the pass by exactly 1 cycle.
- FC1_CTRL_PAUSE_EN undefined: the `pause` port is absent and RUN never stalls.

## Structure
- Package fc1_ctrl_pkg: the state enum (IDLE, CLEAR, RUN, DRAIN, DONE) and default constants for INPUT_NODES, ADDR_W, MEM_LAT and PE_LAT.
- One sub-module, fc1_valid_delay: a parameterised DEPTH shift register that produces pe_valid from rd_en and clears on reset.

## Test plan
- Nominal pass with defaults: start pulse in cycle 0 → pe_clear in cycle 1; addra 0..783 in cycles 2..785; 784 pe_valid pulses in cycles 3..786; done and out_latch in cycle 789 only; busy low in cycle 790.
- start held high for 10 cycles, plus a start in the DONE cycle → exactly one pass and no second CLEAR.
- reset asserted in cycle 400 of a pass → the next cycle has all outputs 0 and state IDLE, no done pulse follows, and a fresh start gives the full nominal timeline.
- MEM_LAT=3, PE_LAT=0, INPUT_NODES=8 → pe_valid in cycles 5..12, done in cycle 13.
- With FC1_CTRL_PAUSE_EN, pause high for cycles 10..14 → addra holds 8 during the pause, pe_valid has a 5-cycle gap, done moves to cycle 794, and the pe_valid count stays 784.
- Back-to-back: start in cycle 0 and cycle 790 → second CLEAR in cycle 791 and second done in cycle 1579.

Source files
------------

// File: rtl/fc1_ctrl_pkg.sv
// Shared state encoding and default sizing for the FC1 sequencer.
// Defaults match the 784-input first fully connected layer.
package fc1_ctrl_pkg;

    localparam int INPUT_NODES_DEF = 784;
    localparam int ADDR_W_DEF      = 10;
    localparam int MEM_LAT_DEF     = 1;
    localparam int PE_LAT_DEF      = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fc1_valid_delay.sv
// Fixed-depth shift register that aligns the PE accumulate strobe
// with the memory read latency; flushed by reset.
module fc1_valid_delay
    import fc1_ctrl_pkg::*;
#(
    parameter int DEPTH = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic delayed
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (reset) begin
            taps <= '0;
        end else begin
            taps[0] <= strobe;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign delayed = taps[DEPTH-1];

endmodule

// File: rtl/fc1_seq_ctrl.sv
// FC1 PE-array sequencer: clear, stream addresses, drain, then pulse done.
// Define FC1_CTRL_PAUSE_EN to add the pause input that stalls address issue.
module fc1_seq_ctrl
    import fc1_ctrl_pkg::*;
#(
    parameter int INPUT_NODES = INPUT_NODES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MEM_LAT     = MEM_LAT_DEF,
    parameter int PE_LAT      = PE_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef FC1_CTRL_PAUSE_EN
    input  logic              pause,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] addra,
    output logic              pe_valid,
    output logic              pe_clear,
    output logic              busy,
    output logic              done,
    output logic              out_latch
);

    localparam int DRAIN_CYC = MEM_LAT + PE_LAT;
    localparam int CNT_W     = $clog2(DRAIN_CYC + 1);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(INPUT_NODES - 1);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(DRAIN_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;
    logic             stall;

`ifdef FC1_CTRL_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    // In RUN the current addra has always been issued already,
    // so resuming after a stall advances straight to the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            addra     <= '0;
            pe_clear  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_latch <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        pe_clear <= 1'b1;
                        busy     <= 1'b1;
                        addra    <= '0;
                    end
                end
                CLEAR: begin
                    state    <= RUN;
                    pe_clear <= 1'b0;
                    rd_en    <= 1'b1;
                end
                RUN: begin
                    if (stall) begin
                        rd_en <= 1'b0;
                    end else if (addra == LAST) begin
                        state     <= DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        addra <= addra + ADDR_W'(1);
                        rd_en <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == CNT_END) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        out_latch <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    out_latch <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fc1_valid_delay #(
        .DEPTH(MEM_LAT)
    ) u_valid_delay (
        .clk    (clk),
        .reset  (reset),
        .strobe (rd_en),
        .delayed(pe_valid)
    );

endmodule

// File: tb/tb_fc1_seq_ctrl.sv
// Bench for fc1_seq_ctrl: directed passes plus a random tail, checked
// per cycle against a pass-timeline model.
module tb_fc1_seq_ctrl;

    localparam int T  = 784;
    localparam int ML = 1;
    localparam int PL = 2;
    localparam int D  = ML + PL;
    localparam int N  = 8000;
`ifdef FC1_CTRL_PAUSE_EN
    localparam int PX = 5;
`else
    localparam int PX = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
`ifdef FC1_CTRL_PAUSE_EN
    logic       pause;
`endif
    logic       rd_en;
    logic [9:0] addra;
    logic       pe_valid;
    logic       pe_clear;
    logic       busy;
    logic       done;
    logic       out_latch;

    always #5 clk = ~clk;

    fc1_seq_ctrl #(
        .INPUT_NODES(T),
        .ADDR_W     (10),
        .MEM_LAT    (ML),
        .PE_LAT     (PL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef FC1_CTRL_PAUSE_EN
        .pause    (pause),
`endif
        .rd_en    (rd_en),
        .addra    (addra),
        .pe_valid (pe_valid),
        .pe_clear (pe_clear),
        .busy     (busy),
        .done     (done),
        .out_latch(out_latch)
    );

    bit st [N];
    bit ps [N];
    bit rs [N];

    bit e_rd [N];
    bit e_clr[N];
    bit e_bsy[N];
    bit e_dn [N];
    bit e_v  [N];
    int e_ad [N];

    bit o_rd [N];
    bit o_clr[N];
    bit o_bsy[N];
    bit o_dn [N];
    bit o_lat[N];
    bit o_v  [N];
    int o_ad [N];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Pass timeline: clear, T issues (stalls repeat the last address),
    // D drain cycles, one done cycle; any reset aborts to all-zero.
    function automatic void build_model();
        int n, x, k, hold;
        bit ab;
        for (int i = 0; i < N; i++) begin
            e_rd[i] = 0; e_clr[i] = 0; e_bsy[i] = 0;
            e_dn[i] = 0; e_v[i] = 0; e_ad[i] = 0;
        end
        hold = 0;
        n = 0;
        while (n < N - 1) begin
            x = n + 1;
            if (rs[n]) begin
                hold = 0;
                e_ad[x] = 0;
                n = x;
                continue;
            end
            if (!st[n]) begin
                e_ad[x] = hold;
                n = x;
                continue;
            end
            e_clr[x] = 1;
            e_bsy[x] = 1;
            e_ad[x] = 0;
            hold = 0;
            ab = 0;
            k = 0;
            while (1) begin
                if (x >= N - 1 || rs[x]) begin
                    ab = 1;
                    break;
                end
                if (k > 0 && ps[x]) begin
                    x++;
                    e_bsy[x] = 1;
                    e_ad[x] = k - 1;
                    continue;
                end
                if (k == T) break;
                x++;
                e_rd[x] = 1;
                e_bsy[x] = 1;
                e_ad[x] = k;
                k++;
            end
            for (int d = 0; d < D && !ab; d++) begin
                if (x >= N - 1 || rs[x]) ab = 1;
                else begin
                    x++;
                    e_bsy[x] = 1;
                    e_ad[x] = T - 1;
                end
            end
            if (!ab) begin
                if (x >= N - 1 || rs[x]) ab = 1;
                else begin
                    x++;
                    e_bsy[x] = 1;
                    e_dn[x] = 1;
                    e_ad[x] = T - 1;
                end
            end
            if (!ab) begin
                hold = T - 1;
                // a start seen in the done cycle is dropped
                if (x < N - 1 && !rs[x]) begin
                    x++;
                    e_ad[x] = hold;
                end
            end
            n = x;
        end
        for (int i = ML; i < N; i++) begin
            e_v[i] = e_rd[i - ML];
            for (int j = i - ML; j < i; j++)
                if (rs[j]) e_v[i] = 0;
        end
    endfunction

    function automatic int count_of(input int sel, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                0: c += int'(o_dn[i]);
                1: c += int'(o_clr[i]);
                default: c += int'(o_v[i]);
            endcase
        end
        return c;
    endfunction

    function automatic int first_of(input int sel, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                0: if (o_dn[i]) return i;
                1: if (o_clr[i]) return i;
                default: if (o_v[i]) return i;
            endcase
        end
        return -1;
    endfunction

    initial begin
        logic [15:0] ov, ev;
        for (int i = 0; i < N; i++) begin
            st[i] = 0; ps[i] = 0; rs[i] = 0;
        end
        rs[0] = 1;
        rs[1] = 1;
        for (int i = 5; i < 15; i++) st[i] = 1;
        st[794 + PX] = 1;
`ifdef FC1_CTRL_PAUSE_EN
        for (int i = 15; i < 20; i++) ps[i] = 1;
`endif
        st[1000] = 1;
        rs[1400] = 1;
        st[1410] = 1;
        st[2300] = 1;
        st[3090] = 1;
        for (int i = 4000; i < N; i++) begin
            st[i] = ($urandom_range(0, 59) == 0);
`ifdef FC1_CTRL_PAUSE_EN
            ps[i] = ($urandom_range(0, 7) == 0);
`endif
            rs[i] = ($urandom_range(0, 2999) == 0);
        end
        build_model();

        reset = rs[0];
        start = st[0];
`ifdef FC1_CTRL_PAUSE_EN
        pause = ps[0];
`endif
        for (int n = 0; n < N - 1; n++) begin
            @(posedge clk);
            #1;
            o_rd[n+1]  = rd_en;
            o_ad[n+1]  = int'(addra);
            o_v[n+1]   = pe_valid;
            o_clr[n+1] = pe_clear;
            o_bsy[n+1] = busy;
            o_dn[n+1]  = done;
            o_lat[n+1] = out_latch;
            ov = {rd_en, addra, pe_valid, pe_clear, busy, done, out_latch};
            ev = {e_rd[n+1], 10'(e_ad[n+1]), e_v[n+1], e_clr[n+1],
                  e_bsy[n+1], e_dn[n+1], e_dn[n+1]};
            chk($sformatf("cyc%0d", n + 1), int'(ov), int'(ev));
            reset = rs[n+1];
            start = st[n+1];
`ifdef FC1_CTRL_PAUSE_EN
            pause = ps[n+1];
`endif
        end

        chk("reset_busy", int'(o_bsy[1]), 0);
        chk("reset_addr", o_ad[1], 0);
        chk("p1_clear_cyc", first_of(1, 5, 999), 6);
        chk("p1_clear_cnt", count_of(1, 5, 999), 1);
        chk("p1_first_valid", first_of(2, 5, 999), 8);
        chk("p1_valid_cnt", count_of(2, 5, 999), T);
        chk("p1_addr_rel13", o_ad[18], PX > 0 ? 8 : 11);
        chk("p1_last_addr", o_ad[790 + PX], T - 1);
        chk("p1_last_rd", int'(o_rd[790 + PX]), 1);
        chk("p1_rd_off", int'(o_rd[791 + PX]), 0);
        chk("p1_done_cyc", first_of(0, 5, 999), 794 + PX);
        chk("p1_done_cnt", count_of(0, 5, 999), 1);
        chk("p1_latch", int'(o_lat[794 + PX]), 1);
        chk("p1_idle", int'(o_bsy[795 + PX]), 0);
        chk("abort_busy", int'(o_bsy[1401]), 0);
        chk("abort_valid", int'(o_v[1401]), 0);
        chk("abort_no_done", count_of(0, 1000, 1409), 0);
        chk("p2_done_cyc", first_of(0, 1410, 2299), 2199);
        chk("p2_valid_cnt", count_of(2, 1410, 2299), T);
        chk("b2b_clear", int'(o_clr[3091]), 1);
        chk("b2b_done1", first_of(0, 2300, 3099), 3089);
        chk("b2b_done2", first_of(0, 3090, 3999), 3879);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
